// File: rtl/dice_cgra_tid_pipe_mc_if.sv
// Issue, configuration and status bundle for the CGRA thread-ID latency pipe.
// The dispatcher side uses the master modport; the pipe itself uses slave.
interface dice_cgra_tid_pipe_mc_if #(
   parameter int TOTAL_TID   = 512,
   parameter int NUM_LANES   = 4,
   parameter int MAX_LATENCY = 32
);
   localparam int TID_WIDTH = $clog2(TOTAL_TID);
   localparam int CNT_W     = $clog2(MAX_LATENCY + 1);

   logic                 clr;
   logic                 stall;
   logic                 cfg_we;
   logic [CNT_W-1:0]     cfg_latency;
   logic                 cfg_reject;
   logic [CNT_W-1:0]     latency;
   logic                 in_valid;
   logic [TID_WIDTH-1:0] in_tid;
   logic [NUM_LANES-1:0] in_mask;
   logic                 out_valid;
   logic [TID_WIDTH-1:0] out_tid;
   logic [NUM_LANES-1:0] out_mask;
   logic [CNT_W-1:0]     inflight;
   logic                 empty;
   logic                 drain_done;
   logic                 err_drop;

   modport master (
      output clr, stall, cfg_we, cfg_latency, in_valid, in_tid, in_mask,
      input  cfg_reject, latency, out_valid, out_tid, out_mask,
             inflight, empty, drain_done, err_drop
   );

   modport slave (
      input  clr, stall, cfg_we, cfg_latency, in_valid, in_tid, in_mask,
      output cfg_reject, latency, out_valid, out_tid, out_mask,
             inflight, empty, drain_done, err_drop
   );
endinterface

// File: rtl/dice_cgra_tid_pipe_mc.sv
// Stallable multi-lane TID delay line with guarded latency reconfiguration,
// exact in-flight accounting and drain/empty status for bitstream switching.
module dice_cgra_tid_pipe_mc #(
   parameter int TOTAL_TID   = 512,
   parameter int NUM_LANES   = 4,
   parameter int MAX_LATENCY = 32
) (
   input logic                    clk,
   input logic                    rst_n,
   dice_cgra_tid_pipe_mc_if.slave bus
);
   localparam int TID_WIDTH = $clog2(TOTAL_TID);
   localparam int CNT_W     = $clog2(MAX_LATENCY + 1);
   localparam int TAP_W     = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;

   typedef struct packed {
      logic                 valid;
      logic [TID_WIDTH-1:0] tid;
      logic [NUM_LANES-1:0] mask;
   } stage_t;

   stage_t           stages [MAX_LATENCY];
   stage_t           tap;
   logic [TAP_W-1:0] tap_idx;
   logic [CNT_W-1:0] latency_q;
   logic [CNT_W-1:0] inflight_q;
   logic [CNT_W-1:0] inflight_nxt;
   logic [CNT_W-1:0] cfg_clamped;
   logic             accept;
   logic             fire;
   logic             cfg_apply;
   logic             drain_q;
   logic             reject_q;
   logic             err_q;

   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path can leave it unassigned and infer a latch.
      tap_idx = TAP_W'(latency_q - CNT_W'(1));
      tap     = stages[tap_idx];
      if (latency_q == '0) begin
         tap.valid = bus.in_valid;
         tap.tid   = bus.in_tid;
         tap.mask  = bus.in_mask;
      end
      accept       = bus.in_valid & ~bus.stall;
      fire         = tap.valid & ~bus.stall;
      inflight_nxt = inflight_q + CNT_W'(accept) - CNT_W'(fire);
      // A new latency is only safe when nothing is in flight and nothing is entering.
      cfg_apply    = bus.cfg_we & ~bus.clr & ~bus.in_valid & (inflight_q == '0);
      cfg_clamped  = (bus.cfg_latency > CNT_W'(MAX_LATENCY)) ? CNT_W'(MAX_LATENCY)
                                                             : bus.cfg_latency;
   end

   // NOTE: the payload flops are reset along with the valids so out_tid/out_mask read zero out of reset instead of X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MAX_LATENCY; k++) stages[k] <= '0;
      end else if (bus.clr || cfg_apply) begin
         for (int k = 0; k < MAX_LATENCY; k++) stages[k].valid <= 1'b0;
      end else if (!bus.stall) begin
         // NOTE: non-blocking assignment makes each stage take its neighbour's pre-edge value; blocking would collapse the shift.
         stages[0].valid <= accept;
         stages[0].tid   <= bus.in_tid;
         stages[0].mask  <= bus.in_mask;
         for (int k = 1; k < MAX_LATENCY; k++) stages[k] <= stages[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latency_q  <= CNT_W'(1);
         inflight_q <= '0;
         drain_q    <= 1'b0;
         reject_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         reject_q <= bus.cfg_we & ~bus.clr & ~cfg_apply;
         if (bus.clr) begin
            inflight_q <= '0;
            drain_q    <= 1'b0;
            err_q      <= 1'b0;
         end else begin
            inflight_q <= inflight_nxt;
            drain_q    <= (inflight_q != '0) && (inflight_nxt == '0);
            err_q      <= err_q | (bus.in_valid & bus.stall);
            if (cfg_apply) latency_q <= cfg_clamped;
         end
      end
   end

   assign bus.out_valid  = fire;
   assign bus.out_tid    = tap.tid;
   assign bus.out_mask   = tap.mask;
   assign bus.latency    = latency_q;
   assign bus.inflight   = inflight_q;
   assign bus.empty      = (inflight_q == '0);
   assign bus.drain_done = drain_q;
   assign bus.cfg_reject = reject_q;
   assign bus.err_drop   = err_q;
endmodule
